// File: rtl/arb_out_fifo_if.sv
// rtl/arb_out_fifo_if.sv - handshake and status bundle between arbiter, FIFO and consumer
interface arb_out_fifo_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic             valid_in;
    logic [WIDTH-1:0] data_in;
    logic             ready_out;
    logic             valid_out;
    logic [WIDTH-1:0] data_out;
    logic             ready_in;
    logic [CW-1:0]    count;
    logic             almost_full;

    // slave is the FIFO side; master drives upstream words and downstream ready
    modport slave (
        input  valid_in, data_in, ready_in,
        output ready_out, valid_out, data_out, count, almost_full
    );

    modport master (
        output valid_in, data_in, ready_in,
        input  ready_out, valid_out, data_out, count, almost_full
    );
endinterface

// File: rtl/arb_out_fifo.sv
// rtl/arb_out_fifo.sv - FWFT FIFO behind the 4-way arbiter with occupancy and almost-full
// All flags come from registered state, so downstream ready never reaches upstream ready.
module arb_out_fifo #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 8,
    parameter int AF_LEVEL = 6
) (
    input  logic               clk,
    input  logic               rst,
    arb_out_fifo_if.slave      bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push, pop;

    assign bus.ready_out   = (count_q != CW'(DEPTH)) && !rst;
    assign bus.valid_out   = (count_q != '0);
    assign bus.almost_full = (count_q >= CW'(AF_LEVEL));
    assign bus.data_out    = mem[rd_ptr_q];
    assign bus.count       = count_q;

    // ready_out already folds in rst, so a word offered during reset is never written
    assign push = bus.valid_in && bus.ready_out;
    assign pop  = bus.valid_out && bus.ready_in;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= bus.data_in;
        end
    end
endmodule
